// File: rtl/conv_enc_213.sv
// Rate-1/2 (2,1,3) convolutional encoder, G0=111 / G1=101, with valid/ready handshakes.
// Define CONV213_TAIL_EN to append two zero tail bits that terminate every frame in state 00.
module conv_enc_213 #(
    parameter int         FRAME_LEN = 64,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       In_valid,
    output logic       In_ready,
    input  logic       In_bit,
    output logic       Tx_valid,
    input  logic       Tx_ready,
    output logic [1:0] Tx,
    output logic       Tx_sof,
    output logic       Tx_eof
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL1, TAIL2} state_t;

    localparam logic [15:0] LAST = 16'(FRAME_LEN);
`ifdef CONV213_TAIL_EN
    localparam state_t AFTER_DATA = TAIL1;
`else
    localparam state_t AFTER_DATA = IDLE;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  sreg;
    logic [1:0]  sreg_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        adv;
    logic        accept;
    logic        last_bit;
    logic        produce;
    logic        u;
    logic [1:0]  tx_nxt;
    logic        sof_nxt;
    logic        eof_nxt;

    assign adv      = !Tx_valid | Tx_ready;
    assign In_ready = Reset_n & adv & ((state == IDLE) | (state == DATA));
    assign accept   = In_valid & In_ready;
    assign last_bit = (state == IDLE) ? (LAST == 16'd1) : ((cnt + 16'd1) == LAST);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = last_bit ? AFTER_DATA : DATA;
            DATA:    if (accept && last_bit) state_nxt = AFTER_DATA;
`ifdef CONV213_TAIL_EN
            TAIL1:   if (adv) state_nxt = TAIL2;
            TAIL2:   if (adv) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Symbol to load into the output stage: a data bit on accept, otherwise a zero tail bit.
    always_comb begin
        produce = 1'b0;
        u       = 1'b0;
        sof_nxt = 1'b0;
        eof_nxt = 1'b0;
        cnt_nxt = cnt;
        if (accept) begin
            produce = 1'b1;
            u       = In_bit;
            sof_nxt = (state == IDLE);
            cnt_nxt = (state == IDLE) ? 16'd1 : cnt + 16'd1;
`ifndef CONV213_TAIL_EN
            eof_nxt = last_bit;
`endif
        end
`ifdef CONV213_TAIL_EN
        else if (adv && ((state == TAIL1) || (state == TAIL2))) begin
            produce = 1'b1;
            eof_nxt = (state == TAIL2);
        end
`endif
        tx_nxt   = {^({u, sreg} & G0), ^({u, sreg} & G1)};
        sreg_nxt = {u, sreg[1]};
`ifndef CONV213_TAIL_EN
        // Unterminated frames still restart the next frame from state 00.
        if (accept && last_bit) sreg_nxt = 2'b00;
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Tx       <= 2'b00;
            Tx_valid <= 1'b0;
            Tx_sof   <= 1'b0;
            Tx_eof   <= 1'b0;
            sreg     <= 2'b00;
            cnt      <= 16'd0;
        end else if (adv) begin
            Tx_valid <= produce;
            if (produce) begin
                Tx     <= tx_nxt;
                Tx_sof <= sof_nxt;
                Tx_eof <= eof_nxt;
                sreg   <= sreg_nxt;
                cnt    <= cnt_nxt;
            end
        end
    end

endmodule

// File: doc/conv_enc_213.md
Name: conv_enc_213

Overview:
- Rate-1/2 convolutional encoder for the (2,1,3) code; it is the transmit-side counterpart of the (2,1,3) Viterbi decoder.
- Constraint length 3, 4 states, generators G0=111 and G1=101.
- Accepts a serial information bit stream in fixed-length frames and emits one 2-bit code symbol per bit.
- Appends two zero tail bits so that every frame ends in state 00, which is what the decoder traceback expects.

Parameters:
- FRAME_LEN, 64: information bits per frame; legal range 1..65535.
- G0, 3'b111: generator for Tx[1], ordered {u, s1, s2}.
- G1, 3'b101: generator for Tx[0], ordered {u, s1, s2}.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- In_valid  input  1  In_bit is valid.
- In_ready  output  1  encoder accepts In_bit this cycle.
- In_bit  input  1  information bit.
- Tx_valid  output  1  Tx holds a valid code symbol.
- Tx_ready  input  1  downstream accepts Tx this cycle.
- Tx  output  2  code symbol; Tx[1] = G0 parity, Tx[0] = G1 parity.
- Tx_sof  output  1  Tx is the first symbol of a frame.
- Tx_eof  output  1  Tx is the last symbol of a frame.

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is synchronous and active-low.
- Reset values while Reset_n=0: Tx=00, Tx_valid=0, Tx_sof=0, Tx_eof=0, shift register {s1,s2}=00, bit counter=0, FSM=IDLE. In_ready=0 during reset.
- Reset mid-frame discards the partial frame. The first cycle after reset is IDLE with In_ready=1.
- Advance condition: adv = !Tx_valid | Tx_ready. Output is a single register stage.
- In_ready = adv & (state is IDLE or DATA). It is combinational from Tx_valid/Tx_ready/state and never depends on In_valid.
- Parity: Tx[1] = ^({u,s1,s2} & G0), Tx[0] = ^({u,s1,s2} & G1).
- Shift update on each produced symbol: s2 <= s1, s1 <= u.
- Latency: a bit accepted in cycle n appears on Tx with Tx_valid=1 in cycle n+1.
- Hold rule: while Tx_valid=1 and Tx_ready=0, Tx, Tx_sof and Tx_eof stay stable and no state changes.
- If adv=1 and no symbol is produced this cycle, Tx_valid <= 0.
- FSM states: IDLE, DATA, TAIL1, TAIL2.
- IDLE:
  - On accept, go to DATA with Tx_sof=1 and bit counter=1.
  - If FRAME_LEN=1, go directly to TAIL1 instead.
  - {s1,s2} is 00 on entry.
- DATA:
  - Each accept increments the bit counter.
  - The accept that makes the counter equal FRAME_LEN goes to TAIL1.
  - Gaps (In_valid=0) are allowed; the state is held.
- TAIL1: when adv=1, emit the symbol for u=0, then go to TAIL2.
- TAIL2: when adv=1, emit the symbol for u=0 with Tx_eof=1, then go to IDLE. The shift register is then 00.
- Back-to-back frames: In_ready is reasserted the cycle after TAIL2 emits. This gives a 2-cycle input bubble per frame; no symbol-rate bubble when input is continuous.
- Tx_sof and Tx_eof are never both 1 (frame length is ≥ 3 symbols with tail).
- Simultaneous accept and downstream pop in the same cycle is legal: full throughput is 1 symbol/cycle.
- Bit counter is 16 bits and never wraps within a legal FRAME_LEN.

Optional Feature:
- Macro name: CONV213_TAIL_EN.
- Defined: zero-tail termination as described above; the frame is FRAME_LEN+2 symbols and Tx_eof is on the second tail symbol.
- Undefined:
  - TAIL1 and TAIL2 are not built.
  - The last data accept goes to IDLE with Tx_eof=1 on that data symbol.
  - {s1,s2} is forced to 00 on the transition to IDLE; the frame is FRAME_LEN symbols and is not terminated.

Test Plan:
- Basic encode: FRAME_LEN=4, TAIL_EN on, bits 1,0,1,1 with Tx_ready=1 -> Tx sequence 11,10,00,01,01,11. Tx_sof on 11 (first), Tx_eof on the final 11. In_ready=0 for 2 cycles.
- Backpressure: same stimulus, Tx_ready=0 for 3 cycles after the first symbol -> Tx holds 11 with Tx_valid=1 and In_ready=0 throughout; the sequence resumes unchanged.
- Input gaps and back-to-back frames: two frames 1011 then 0000 with random In_valid gaps -> frame 2 is 00,00,00,00,00,00 with its own Tx_sof/Tx_eof. This proves the state was 00 at the frame boundary.
- Reset mid-frame: Reset_n=0 for 1 cycle after 2 bits of a 1011 frame -> Tx_valid=0 and Tx=00 next cycle. A new frame 1011 then produces 11,10,00,01,01,11.
- TAIL_EN off: FRAME_LEN=4, bits 1,0,1,1 -> Tx 11,10,00,01 with Tx_eof on 01. Next frame 1000 -> 11,10,11,00 (encoder restarts from 00).
- Edge case FRAME_LEN=1, TAIL_EN on: bit 1 -> Tx 11,10,11 with Tx_sof on the first symbol and Tx_eof on the third.
